order_timer: RTL
================

# order_timer

Parametrised reservation/countdown timer for the appliance controller. While idle, a button steps the reserved time up in fixed increments with wrap-around. While running, the timer counts down one unit per `TICK_CYCLES` clocks and can be cleared by the clean button. Adds a pause mode, tick/done strobes and an optional decrement button.

## Interface
- `TICK_CYCLES`, 100_000_000: clocks per time unit (1 s at 100 MHz); ≥ 2.
- `STEP`, 10: increment/decrement step of `rest_time`; ≥ 1.
- `MAX_TIME`, 60: largest settable value; multiple of `STEP`.
- `WIDTH`, 7: width of `rest_time`; 2^WIDTH > `MAX_TIME`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `power_light` in 1: 1 = appliance powered; 0 clears timer.
- `order_btn` in 1: add-time button, level; acts on rising edge.
- `clean_btn` in 1: clear-time button, level; acts on rising edge.
- `run_state` in 2: 00 idle/set, 01 run, 10 pause, 11 stop.
- `dec_btn` in 1: subtract-time button, rising edge; present only with `ORDER_TIMER_DEC_EN`.
- `rest_time` out `WIDTH`: remaining time in units.
- `tick` out 1: one-cycle pulse on each countdown decrement.
- `done` out 1: one-cycle pulse when countdown reaches 0.

## Operation
- Edge detect: each button has a previous-value register, updated every cycle in every state and power condition; cleared only by `rst`. Edge = input 1 and previous value 0. A button held across a state change does not retrigger.
- Priority: `rst` > `power_light`==0 > `run_state` behaviour.
- `rst`: `rest_time`=0, cycle counter=0, `tick`=0, `done`=0, edge registers=0.
- Power off: `rest_time`=0, counter=0, `tick`=`done`=0.
- Idle (00): counter=0. `order_btn` edge: `rest_time` = `rest_time`+`STEP`; if the result exceeds `MAX_TIME`, it becomes 0. With defaults, the sequence is 0,10,…,60,0. `clean_btn` is ignored.
- Run (01):
  - `clean_btn` edge: `rest_time`=0 and counter=0, with no `tick` or `done`.
  - Else if `rest_time`==0: counter=0 and `rest_time` holds.
  - Else: counter increments. When counter==`TICK_CYCLES`-1, `rest_time` decrements by 1, counter returns to 0 and `tick`=1. If `rest_time` was 1, `done`=1 as well.
  - Add/decrement buttons are ignored.
- Pause (10): counter and `rest_time` hold, and all buttons are ignored. Returning to 01 resumes the countdown from the held counter value.
- Stop (11): counter=0, `rest_time` holds, and buttons are ignored.
- Counter width is $clog2(`TICK_CYCLES`). `rest_time` arithmetic is done at `WIDTH`+1 bits before the wrap compare, so no overflow aliasing occurs.

## Timing
- All outputs are registered. A button edge sampled at clock edge t updates `rest_time` at t.
- From entering run with a nonzero value, the first decrement occurs `TICK_CYCLES` cycles later, then one decrement every `TICK_CYCLES` cycles.
- `tick` and `done` are high for exactly the cycle in which the new `rest_time` is visible. Otherwise they are 0.
- A clean edge coinciding with the terminal count: clean wins, so `rest_time`=0, with no `tick` and no `done`.
- A reset or power-off mid-count takes effect at the next edge, and no `done` is generated.

## Configuration
- `ORDER_TIMER_DEC_EN` defined:
  - Adds the `dec_btn` port.
  - In idle, a `dec_btn` edge sets `rest_time` = `rest_time`-`STEP` if `rest_time` ≥ `STEP`; else `rest_time` = `MAX_TIME` (wrap).
  - Simultaneous `order_btn` and `dec_btn` edges leave `rest_time` unchanged.
- Not defined: no `dec_btn` port and no decrement logic. Behaviour is otherwise identical.

## Test plan
- `TICK_CYCLES`=4, defaults otherwise: 7 `order_btn` pulses in idle → `rest_time` 10,20,30,40,50,60,0.
- Set 20, switch to run → `tick` every 4 cycles, `rest_time` 19,18,…. At the 1→0 step, `tick` and `done` pulse together once; afterwards `rest_time` stays 0 with no further pulses.
- Set 10, run 6 cycles (one decrement to 9, counter at 2), pause for 20 cycles, then resume → `rest_time` holds 9 during pause; the next decrement to 8 occurs 2 cycles after resume.
- Run with `rest_time`=5: a `clean_btn` rising edge on the same cycle as the terminal count → `rest_time`=0, with `tick`=0 and `done`=0. Holding `order_btn` high while returning to idle causes no increment.
- `rst` or `power_light`=0 asserted mid-count at `rest_time`=30 → next cycle `rest_time`=0, `tick`=`done`=0. `rst` wins when asserted together with power on.
- With `ORDER_TIMER_DEC_EN`, in idle at 0: `dec_btn` edge → 60; `dec_btn` edge → 50; simultaneous `order_btn` and `dec_btn` edges → 50.

Source files
------------

// File: rtl/order_timer_if.sv
// order_timer_if: control/status bundle between the appliance controller and
// the reservation/countdown timer.
//
// Configuration macro: ORDER_TIMER_DEC_EN adds the dec_btn signal.
//
// Signals
//   power_light  1 = appliance powered; 0 clears the timer
//   order_btn    add-time button (level, rising edge acts)
//   clean_btn    clear-time button (level, rising edge acts)
//   run_state    00 idle/set, 01 run, 10 pause, 11 stop
//   dec_btn      subtract-time button (only with ORDER_TIMER_DEC_EN)
//   rest_time    remaining time in units
//   tick         one-cycle pulse on each countdown decrement
//   done         one-cycle pulse when the countdown reaches 0
//
// Handshake: there is no valid/ready flow control. Every input is sampled on
// each rising clock edge; buttons act on a 0->1 change between two samples.
// Outputs are registered and valid every cycle after reset.
//
// Modports: master = controller side (drives inputs), slave = timer side.
interface order_timer_if #(
  parameter int WIDTH = 7
) ();
  logic             power_light;
  logic             order_btn;
  logic             clean_btn;
  logic [1:0]       run_state;
`ifdef ORDER_TIMER_DEC_EN
  logic             dec_btn;
`endif
  logic [WIDTH-1:0] rest_time;
  logic             tick;
  logic             done;

  modport master (
`ifdef ORDER_TIMER_DEC_EN
    output dec_btn,
`endif
    output power_light,
    output order_btn,
    output clean_btn,
    output run_state,
    input  rest_time,
    input  tick,
    input  done
  );

  modport slave (
`ifdef ORDER_TIMER_DEC_EN
    input  dec_btn,
`endif
    input  power_light,
    input  order_btn,
    input  clean_btn,
    input  run_state,
    output rest_time,
    output tick,
    output done
  );
endinterface

// File: rtl/order_timer.sv
// order_timer: reservation/countdown timer.
//
// In idle the order button steps rest_time up by STEP, wrapping to 0 past
// MAX_TIME. In run, rest_time counts down one unit every TICK_CYCLES clocks
// with tick/done strobes; a clean edge clears it. Pause freezes everything,
// stop clears only the cycle counter.
//
// Configuration macro: ORDER_TIMER_DEC_EN adds a decrement button in idle
// (wraps from below STEP to MAX_TIME).
//
// Ports
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   order_timer_if.slave (power, buttons, run_state, rest_time,
//         tick, done)
module order_timer #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int STEP        = 10,
  parameter int MAX_TIME    = 60,
  parameter int WIDTH       = 7
) (
  input  logic         clk,
  input  logic         rst,
  order_timer_if.slave bus
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_TERM = CW'(TICK_CYCLES - 1);
  // Extended-width constants: arithmetic at WIDTH+1 bits avoids aliasing
  // an overflowing sum back into the legal range.
  localparam logic [WIDTH:0] STEP_X   = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] MAX_X    = (WIDTH + 1)'(MAX_TIME);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_PAUSE = 2'b10,
    MODE_STOP  = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(bus.run_state);

  logic [WIDTH-1:0] rest_q, rest_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             order_q, clean_q;

  logic             order_edge, clean_edge, dec_edge;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] inc_val;

  assign order_edge = bus.order_btn & ~order_q;
  assign clean_edge = bus.clean_btn & ~clean_q;

  assign sum_x   = {1'b0, rest_q} + STEP_X;
  assign inc_val = (sum_x > MAX_X) ? '0 : sum_x[WIDTH-1:0];

`ifdef ORDER_TIMER_DEC_EN
  logic             dec_q;
  logic [WIDTH-1:0] dec_val;

  assign dec_edge = bus.dec_btn & ~dec_q;
  assign dec_val  = ({1'b0, rest_q} >= STEP_X) ? (rest_q - WIDTH'(STEP))
                                                : WIDTH'(MAX_TIME);
`else
  assign dec_edge = 1'b0;
`endif

  // Edge-detect history follows the buttons in every mode and power state,
  // so a button held across a mode change never retriggers.
  always_ff @(posedge clk) begin
    if (rst) begin
      order_q <= 1'b0;
      clean_q <= 1'b0;
    end else begin
      order_q <= bus.order_btn;
      clean_q <= bus.clean_btn;
    end
  end

`ifdef ORDER_TIMER_DEC_EN
  always_ff @(posedge clk) begin
    if (rst) dec_q <= 1'b0;
    else     dec_q <= bus.dec_btn;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rest_q <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rest_q <= rest_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    rest_d = rest_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    done_d = 1'b0;
    if (!bus.power_light) begin
      rest_d = '0;
      cnt_d  = '0;
    end else begin
      unique case (mode)
        MODE_IDLE: begin
          cnt_d = '0;
          // Simultaneous add and subtract edges cancel out.
          if (order_edge && !dec_edge) begin
            rest_d = inc_val;
          end
`ifdef ORDER_TIMER_DEC_EN
          else if (dec_edge && !order_edge) begin
            rest_d = dec_val;
          end
`endif
        end
        MODE_RUN: begin
          // Clear beats a coincident terminal count: no tick, no done.
          if (clean_edge) begin
            rest_d = '0;
            cnt_d  = '0;
          end else if (rest_q == '0) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_TERM) begin
            rest_d = rest_q - WIDTH'(1);
            cnt_d  = '0;
            tick_d = 1'b1;
            done_d = (rest_q == WIDTH'(1));
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        MODE_PAUSE: begin
          // Counter and time frozen so a resume continues mid-unit.
        end
        MODE_STOP: begin
          cnt_d = '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rest_time = rest_q;
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;

endmodule
